// File: rtl/asg_seg_sequencer.sv
// Segment sequencer: plays a table of waveform segments out of one ASG channel.
// Ports: desc_* write the table; start/stop/loop/nseg control; wrap_i from channel;
//   set_*/trig_sw_o drive the channel; busy_o/seg_idx_o/done_o report progress.
module asg_seg_sequencer #(
  parameter int RSZ  = 14,
  parameter int NSEG = 8,
  parameter int SW   = 3
) (
  input  logic            dac_clk_i,
  input  logic            dac_rstn_i,
  input  logic            desc_we_i,
  input  logic [SW-1:0]   desc_slot_i,
  input  logic [2:0]      desc_fld_i,
  input  logic [31:0]     desc_wdata_i,
  input  logic [SW:0]     nseg_i,
  input  logic            loop_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            wrap_i,
  output logic [RSZ+15:0] set_ofs_o,
  output logic [RSZ+15:0] set_size_o,
  output logic [RSZ+15:0] set_step_o,
  output logic [15:0]     set_ncyc_o,
  output logic            set_rst_o,
  output logic            set_zero_o,
  output logic            trig_sw_o,
  output logic            busy_o,
  output logic [SW-1:0]   seg_idx_o,
  output logic            done_o
);

  localparam int PW = RSZ + 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM1, S_ARM2,
    S_FIRE, S_RUN,  S_GAP,  S_DONE
  } state_t;

  state_t r_st, w_nxt;

  logic [PW-1:0] r_ofs_t  [NSEG];
  logic [PW-1:0] r_size_t [NSEG];
  logic [PW-1:0] r_step_t [NSEG];
  logic [15:0]   r_ncyc_t [NSEG];
  logic [15:0]   r_gap_t  [NSEG];

  logic [SW-1:0] r_idx, w_idx_nxt;
  logic [15:0]   r_wcnt, r_gcnt, r_gap;
  logic [SW:0]   w_neff;
  logic          w_last, w_seg_end, w_adv;

  // Table is deliberately not reset.
  always_ff @(posedge dac_clk_i) begin
    if (desc_we_i) begin
      case (desc_fld_i)
        3'd0: r_ofs_t[desc_slot_i]  <= desc_wdata_i[PW-1:0];
        3'd1: r_size_t[desc_slot_i] <= desc_wdata_i[PW-1:0];
        3'd2: r_step_t[desc_slot_i] <= desc_wdata_i[PW-1:0];
        3'd3: r_ncyc_t[desc_slot_i] <= desc_wdata_i[15:0];
        3'd4: r_gap_t[desc_slot_i]  <= desc_wdata_i[15:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_neff = nseg_i;
    if (nseg_i == '0)
      w_neff = (SW+1)'(1);
    else if (nseg_i > (SW+1)'(NSEG))
      w_neff = (SW+1)'(NSEG);
  end

  assign w_last = ({1'b0, r_idx} >= w_neff - (SW+1)'(1));

  assign w_seg_end = (r_st == S_RUN) && wrap_i &&
                     (set_ncyc_o != 16'd0) &&
                     (r_wcnt == set_ncyc_o - 16'd1);

  always_comb begin
    w_nxt     = r_st;
    w_idx_nxt = r_idx;
    w_adv     = 1'b0;
    unique case (r_st)
      S_IDLE: if (start_i) begin
        w_nxt     = S_LOAD;
        w_idx_nxt = '0;
      end
      S_LOAD: w_nxt = S_ARM1;
      S_ARM1: w_nxt = S_ARM2;
      S_ARM2: w_nxt = S_FIRE;
      S_FIRE: w_nxt = S_RUN;
      S_RUN: if (w_seg_end) begin
        if (r_gap != 16'd0) w_nxt = S_GAP;
        else                w_adv = 1'b1;
      end
      S_GAP: if (r_gcnt == 16'd1) w_adv = 1'b1;
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    // Next-segment decision shared by RUN (no gap) and GAP end.
    if (w_adv) begin
      if (!w_last) begin
        w_nxt     = S_LOAD;
        w_idx_nxt = r_idx + SW'(1);
      end else if (loop_i) begin
        w_nxt     = S_LOAD;
        w_idx_nxt = '0;
      end else begin
        w_nxt = S_DONE;
      end
    end
    if (stop_i) w_nxt = S_IDLE;
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      r_st       <= S_IDLE;
      r_idx      <= '0;
      r_wcnt     <= '0;
      r_gcnt     <= '0;
      r_gap      <= '0;
      set_ofs_o  <= '0;
      set_size_o <= '0;
      set_step_o <= '0;
      set_ncyc_o <= '0;
      seg_idx_o  <= '0;
      set_rst_o  <= 1'b1;
      set_zero_o <= 1'b0;
      trig_sw_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      r_st  <= w_nxt;
      r_idx <= w_idx_nxt;
      if (r_st == S_LOAD) begin
        set_ofs_o  <= r_ofs_t[r_idx];
        set_size_o <= r_size_t[r_idx];
        set_step_o <= r_step_t[r_idx];
        set_ncyc_o <= r_ncyc_t[r_idx];
        r_gap      <= r_gap_t[r_idx];
        seg_idx_o  <= r_idx;
      end
      if (r_st == S_FIRE)
        r_wcnt <= '0;
      else if (r_st == S_RUN && wrap_i && r_wcnt != 16'hFFFF)
        r_wcnt <= r_wcnt + 16'd1;
      if (w_seg_end)
        r_gcnt <= r_gap;
      else if (r_st == S_GAP)
        r_gcnt <= r_gcnt - 16'd1;
      // Outputs follow the state being entered.
      busy_o     <= (w_nxt != S_IDLE);
      trig_sw_o  <= (w_nxt == S_FIRE);
      set_rst_o  <= !(w_nxt == S_FIRE || w_nxt == S_RUN);
      set_zero_o <= (w_nxt == S_GAP);
      done_o     <= (w_nxt == S_DONE);
    end
  end

endmodule
